// File: rtl/paddle_input_ctrl.sv
// Paddle input conditioning: per-button synchroniser and debouncer, then a
// per-player step generator with press-and-hold auto-repeat and cancellation.
module paddle_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 1250000,
  parameter int CNT_W           = 24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req_raw,
  output logic [3:0] pressed,
  output logic [1:0] step_up,
  output logic [1:0] step_down
);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0] s1, s2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= req_raw;
      s2 <= s1;
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_db
    logic [CNT_W-1:0] cnt;
    logic             level;

    // Any disagreement shorter than DEBOUNCE_CYCLES resets the count and is lost.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt   <= '0;
        level <= 1'b0;
      end else if (s2[b] == level) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        cnt   <= '0;
        level <= s2[b];
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end

    assign pressed[b] = level;
  end

  for (genvar p = 0; p < 2; p++) begin : g_player
    state_t           state_q, state_d;
    dir_t             dir, last_q, last_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             fire, up_d, dn_d, up_q, dn_q;

    // Opposing requests cancel: only a single pressed direction counts.
    always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      dir = DIR_NONE;
      case ({pressed[2*p+1], pressed[2*p]})
        2'b01:   dir = DIR_UP;
        2'b10:   dir = DIR_DOWN;
        default: dir = DIR_NONE;
      endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= IDLE;
        last_q  <= DIR_NONE;
        timer_q <= '0;
        up_q    <= 1'b0;
        dn_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        last_q  <= last_d;
        timer_q <= timer_d;
        up_q    <= up_d;
        dn_q    <= dn_d;
      end
    end

    always_comb begin
      state_d = state_q;
      last_d  = last_q;
      timer_d = timer_q;
      case (state_q)
        IDLE: begin
          if (dir != DIR_NONE) begin
            state_d = DELAY;
            last_d  = dir;
            timer_d = '0;
          end
        end
        DELAY: begin
          if (dir == DIR_NONE) begin
            state_d = IDLE;
            timer_d = '0;
          end else if (dir != last_q) begin
            last_d  = dir;
            timer_d = '0;
          end else if (timer_q == RD_LAST) begin
            state_d = REPEAT;
            timer_d = '0;
          end else begin
            timer_d = timer_q + CNT_ONE;
          end
        end
        REPEAT: begin
          if (dir == DIR_NONE) begin
            state_d = IDLE;
            timer_d = '0;
          end else if (dir != last_q) begin
            state_d = DELAY;
            last_d  = dir;
            timer_d = '0;
          end else if (timer_q == RP_LAST) begin
            timer_d = '0;
          end else begin
            timer_d = timer_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          last_d  = DIR_NONE;
          timer_d = '0;
        end
      endcase
    end

    // A pulse always carries the current direction, so up and down are exclusive.
    always_comb begin
      fire = 1'b0;
      case (state_q)
        IDLE:    fire = (dir != DIR_NONE);
        DELAY:   fire = (dir != DIR_NONE) && ((dir != last_q) || (timer_q == RD_LAST));
        REPEAT:  fire = (dir != DIR_NONE) && ((dir != last_q) || (timer_q == RP_LAST));
        default: fire = 1'b0;
      endcase
      up_d = fire && (dir == DIR_UP);
      dn_d = fire && (dir == DIR_DOWN);
    end

    assign step_up[p]   = up_q;
    assign step_down[p] = dn_q;
  end

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Directed bench for paddle_input_ctrl with short debounce/repeat timings;
// step pulses are logged by edge number relative to each scenario start.
module tb_paddle_input_ctrl;

  localparam int DC = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req_raw;
  logic [3:0] pressed;
  logic [1:0] step_up;
  logic [1:0] step_down;

  always #5 clk = ~clk;

  paddle_input_ctrl #(
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .CNT_W          (8)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_raw  (req_raw),
    .pressed  (pressed),
    .step_up  (step_up),
    .step_down(step_down)
  );

  int checks = 0;
  int errors = 0;
  int rel;
  int overlap;
  int p1d_high;
  int q_u0[$], q_u1[$], q_d0[$], q_d1[$];
  int x_u0[$], x_u1[$], x_d0[$], x_d1[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Each iteration lands on the falling edge after posedge number rel.
  task automatic observe(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rel++;
      if (step_up[0])   q_u0.push_back(rel);
      if (step_up[1])   q_u1.push_back(rel);
      if (step_down[0]) q_d0.push_back(rel);
      if (step_down[1]) q_d1.push_back(rel);
      if ((step_up & step_down) != 2'b00) overlap++;
      if (pressed[1]) p1d_high++;
    end
  endtask

  task automatic start_scenario(input string tag);
    req_raw = 4'b0000;
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_rst"}, {24'd0, pressed, step_up, step_down}, 32'd0);
    q_u0.delete(); q_u1.delete(); q_d0.delete(); q_d1.delete();
    x_u0.delete(); x_u1.delete(); x_d0.delete(); x_d1.delete();
    overlap  = 0;
    p1d_high = 0;
    rel      = 0;
    reset_n  = 1'b1;
  endtask

  task automatic compare_q(input string tag, input int got[$], input int exp[$]);
    check({tag, "_n"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  task automatic finish_scenario(input string tag);
    compare_q({tag, "_u0"}, q_u0, x_u0);
    compare_q({tag, "_u1"}, q_u1, x_u1);
    compare_q({tag, "_d0"}, q_d0, x_d0);
    compare_q({tag, "_d1"}, q_d1, x_d1);
    check({tag, "_overlap"}, overlap, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    req_raw = 4'b0000;

    // Short tap, released before the first repeat would be due (edge 17).
    start_scenario("tap");
    req_raw = 4'b0001;
    observe(5);  check("tap_pr5",  {28'd0, pressed}, 32'd0);
    observe(1);  check("tap_pr6",  {28'd0, pressed}, 32'd1);
    observe(2);  req_raw = 4'b0000;
    observe(5);  check("tap_pr13", {28'd0, pressed}, 32'd1);
    observe(1);  check("tap_pr14", {28'd0, pressed}, 32'd0);
    observe(16);
    x_u0 = {7};
    finish_scenario("tap");

    // 3-cycle glitches with 1-cycle gaps never reach the debounce count.
    start_scenario("glitch");
    repeat (5) begin
      req_raw = 4'b0010; observe(3);
      req_raw = 4'b0000; observe(1);
    end
    observe(12);
    check("glitch_pressed1", p1d_high, 0);
    finish_scenario("glitch");

    // Hold for 40 cycles: pressed[2] up at edge 6, down at edge 46.
    start_scenario("hold");
    req_raw = 4'b0100;
    observe(40);
    req_raw = 4'b0000;
    observe(20);
    x_u1 = {7, 17, 20, 23, 26, 29, 32, 35, 38, 41, 44};
    finish_scenario("hold");

    // Down added at rel 10 cancels at edge 17 (would-be repeat); up released at rel 25.
    start_scenario("cancel");
    req_raw = 4'b0001;
    observe(10); req_raw = 4'b0011;
    observe(15); req_raw = 4'b0010;
    observe(15);
    x_u0 = {7};
    x_d0 = {32};
    finish_scenario("cancel");

    // P1 down and P2 up on the same edge, released after 30 cycles.
    start_scenario("indep");
    req_raw = 4'b0110;
    observe(30);
    req_raw = 4'b0000;
    observe(20);
    x_d0 = {7, 17, 20, 23, 26, 29, 32, 35};
    x_u1 = {7, 17, 20, 23, 26, 29, 32, 35};
    finish_scenario("indep");

    // Reset during REPEAT while a pulse is high; button stays held throughout.
    start_scenario("rsthold");
    req_raw = 4'b0001;
    observe(20);
    check("rsthold_pre", {30'd0, step_up}, 32'd1);
    #1 reset_n = 1'b0;
    #1 check("rsthold_clr", {24'd0, pressed, step_up, step_down}, 32'd0);
    observe(2);
    reset_n = 1'b1;
    observe(13);
    x_u0 = {7, 17, 20, 29};
    finish_scenario("rsthold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
